// File: rtl/parking_count_ctrl_pkg.sv
// Shared types and constants for the car-park occupancy controller:
// FSM state encoding, gate selector and the round-robin arbitration helper.
package parking_count_ctrl_pkg;

  localparam int DEFAULT_CAPACITY = 200;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CALC      = 2'd1,
    ST_RESP      = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_t;

  typedef enum logic {
    SEL_ENTRY = 1'b0,
    SEL_EXIT  = 1'b1
  } sel_t;

  // A lone request wins outright; on a tie the gate not served last time wins.
  function automatic sel_t arb_pick(input logic entry_req, input logic exit_req,
                                    input sel_t last_srv);
    sel_t pick;
    if (entry_req && exit_req) begin
      pick = (last_srv == SEL_EXIT) ? SEL_ENTRY : SEL_EXIT;
    end else if (exit_req) begin
      pick = SEL_EXIT;
    end else begin
      pick = SEL_ENTRY;
    end
    return pick;
  endfunction

endpackage

// File: rtl/parking_count_ctrl_if.sv
// Gate-side bus of the occupancy controller: level requests in, one-cycle
// grant/deny pulses and the occupancy status out.
interface parking_count_ctrl_if;

  logic       entry_req;
  logic       exit_req;
  logic       entry_grant;
  logic       entry_deny;
  logic       exit_grant;
  logic       exit_deny;
  logic [7:0] count;
  logic [7:0] free;
  logic       full;
  logic       empty;

  modport master (
    output entry_req, exit_req,
    input  entry_grant, entry_deny, exit_grant, exit_deny,
    input  count, free, full, empty
  );

  modport slave (
    input  entry_req, exit_req,
    output entry_grant, entry_deny, exit_grant, exit_deny,
    output count, free, full, empty
  );

endinterface

// File: rtl/parking_count_ctrl_addsub.sv
// 8-bit ripple-carry adder/subtractor; i_s=1 computes i_a - i_b, and o_cout=0
// then signals a borrow.
module adder_subtractor (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_s,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_b;
  logic [8:0] w_c;

  assign w_b    = i_b ^ {8{i_s}};
  assign w_c[0] = i_s;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign o_sum[gi]  = i_a[gi] ^ w_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & w_b[gi]) | (w_c[gi] & (i_a[gi] ^ w_b[gi]));
  end

  assign o_cout = w_c[8];

endmodule

// File: rtl/parking_count_ctrl.sv
// Occupancy controller: arbitrates entry/exit gate requests onto one shared
// adder/subtractor, keeps the count and answers each request with grant or deny.
module parking_count_ctrl
  import parking_count_ctrl_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic                 clk,
  input  logic                 rst,
  parking_count_ctrl_if.slave  bus
);

  if (CAPACITY < 1 || CAPACITY > 255) begin : g_cap_check
    $error("parking_count_ctrl: CAPACITY must be in 1..255");
  end

  localparam logic [7:0] CAP8 = 8'(CAPACITY);

  state_t     r_state;
  state_t     w_state_next;
  sel_t       r_sel;
  sel_t       r_last_srv;
  sel_t       w_pick;
  logic       r_grant_flag;
  logic [7:0] r_count;
  logic [7:0] r_free;
  logic       r_full;
  logic       r_empty;
  logic       r_entry_grant;
  logic       r_entry_deny;
  logic       r_exit_grant;
  logic       r_exit_deny;

  logic       w_entry_grant_next;
  logic       w_entry_deny_next;
  logic       w_exit_grant_next;
  logic       w_exit_deny_next;

  logic [7:0] w_add_a;
  logic [7:0] w_add_b;
  logic       w_add_s;
  logic [7:0] w_sum;
  logic       w_cout;
  logic       w_ok;
  logic [7:0] w_count_new;
  logic       w_sel_req;
  logic       w_any_req;

  // Idle: free = CAPACITY - count. Calc: count +/- 1 for the selected gate.
  always_comb begin
    w_add_a = CAP8;
    w_add_b = r_count;
    w_add_s = 1'b1;
    if (r_state == ST_CALC) begin
      w_add_a = r_count;
      w_add_b = 8'd1;
      w_add_s = (r_sel == SEL_EXIT);
    end
  end

  adder_subtractor u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_s    (w_add_s),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_any_req   = bus.entry_req | bus.exit_req;
  assign w_pick      = arb_pick(bus.entry_req, bus.exit_req, r_last_srv);
  assign w_sel_req   = (r_sel == SEL_ENTRY) ? bus.entry_req : bus.exit_req;
  assign w_ok        = (r_sel == SEL_ENTRY) ? (r_count != CAP8) : w_cout;
  assign w_count_new = w_ok ? w_sum : r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_any_req) w_state_next = ST_CALC;
      ST_CALC:      w_state_next = ST_RESP;
      ST_RESP:      w_state_next = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!w_sel_req) w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_entry_grant_next = 1'b0;
    w_entry_deny_next  = 1'b0;
    w_exit_grant_next  = 1'b0;
    w_exit_deny_next   = 1'b0;
    if (r_state == ST_RESP) begin
      if (r_sel == SEL_ENTRY) begin
        w_entry_grant_next = r_grant_flag;
        w_entry_deny_next  = !r_grant_flag;
      end else begin
        w_exit_grant_next  = r_grant_flag;
        w_exit_deny_next   = !r_grant_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel         <= SEL_ENTRY;
      r_last_srv    <= SEL_EXIT;
      r_grant_flag  <= 1'b0;
      r_count       <= 8'd0;
      r_free        <= CAP8;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_entry_grant <= 1'b0;
      r_entry_deny  <= 1'b0;
      r_exit_grant  <= 1'b0;
      r_exit_deny   <= 1'b0;
    end else begin
      r_entry_grant <= w_entry_grant_next;
      r_entry_deny  <= w_entry_deny_next;
      r_exit_grant  <= w_exit_grant_next;
      r_exit_deny   <= w_exit_deny_next;
      case (r_state)
        ST_IDLE: begin
          r_free <= w_sum;
          if (w_any_req) r_sel <= w_pick;
        end
        ST_CALC: begin
          r_count      <= w_count_new;
          r_grant_flag <= w_ok;
          r_full       <= (w_count_new == CAP8);
          r_empty      <= (w_count_new == 8'd0);
          r_last_srv   <= r_sel;
        end
        default: ;
      endcase
    end
  end

  assign bus.entry_grant = r_entry_grant;
  assign bus.entry_deny  = r_entry_deny;
  assign bus.exit_grant  = r_exit_grant;
  assign bus.exit_deny   = r_exit_deny;
  assign bus.count       = r_count;
  assign bus.free        = r_free;
  assign bus.full        = r_full;
  assign bus.empty       = r_empty;

endmodule

// File: tb/tb_parking_count_ctrl.sv
// Directed bench for parking_count_ctrl: a default-capacity instance and a
// CAPACITY=3 instance, checked through a model-fed scoreboard of responses.
module tb_parking_count_ctrl;
  import parking_count_ctrl_pkg::*;

  localparam int CAP_A = 200;
  localparam int CAP_B = 3;

  typedef struct packed {
    logic [3:0] pulses;   // {entry_grant, entry_deny, exit_grant, exit_deny}
    logic [7:0] count;
    logic       full;
    logic       empty;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cur;
  logic entry_req_tb;
  logic exit_req_tb;

  parking_count_ctrl_if ifa();
  parking_count_ctrl_if ifb();

  assign ifa.entry_req = entry_req_tb & ~cur;
  assign ifa.exit_req  = exit_req_tb  & ~cur;
  assign ifb.entry_req = entry_req_tb &  cur;
  assign ifb.exit_req  = exit_req_tb  &  cur;

  parking_count_ctrl #(.CAPACITY(CAP_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  parking_count_ctrl #(.CAPACITY(CAP_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic       o_eg, o_ed, o_xg, o_xd, o_full, o_empty;
  logic [7:0] o_count, o_free;

  always_comb begin
    o_eg = cur ? ifb.entry_grant : ifa.entry_grant;
    o_ed = cur ? ifb.entry_deny  : ifa.entry_deny;
    o_xg = cur ? ifb.exit_grant  : ifa.exit_grant;
    o_xd = cur ? ifb.exit_deny   : ifa.exit_deny;
    o_count = cur ? ifb.count : ifa.count;
    o_free  = cur ? ifb.free  : ifa.free;
    o_full  = cur ? ifb.full  : ifa.full;
    o_empty = cur ? ifb.empty : ifa.empty;
  end

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_count;
  int   m_cap;
  sel_t m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input sel_t s);
    exp_t e;
    logic ok;
    if (s == SEL_ENTRY) begin
      ok = (m_count != m_cap);
      if (ok) m_count++;
      e.pulses = ok ? 4'b1000 : 4'b0100;
    end else begin
      ok = (m_count != 0);
      if (ok) m_count--;
      e.pulses = ok ? 4'b0010 : 4'b0001;
    end
    m_last  = s;
    e.count = 8'(m_count);
    e.full  = (m_count == m_cap);
    e.empty = (m_count == 0);
    sb_q.push_back(e);
  endfunction

  function automatic sel_t model_tie_winner();
    return (m_last == SEL_EXIT) ? SEL_ENTRY : SEL_EXIT;
  endfunction

  // Response monitor: every grant/deny pulse consumes one scoreboard entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (o_eg | o_ed | o_xg | o_xd)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, o_eg, o_ed, o_xg, o_xd}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulses", {28'd0, o_eg, o_ed, o_xg, o_xd}, {28'd0, mon_e.pulses});
        check("count",  {24'd0, o_count}, {24'd0, mon_e.count});
        check("full",   {31'd0, o_full},  {31'd0, mon_e.full});
        check("empty",  {31'd0, o_empty}, {31'd0, mon_e.empty});
      end
    end
  end

  task automatic wait_pulse(input sel_t s, output int waited);
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      waited++;
      if (s == SEL_ENTRY ? (o_eg | o_ed) : (o_xg | o_xd)) return;
    end
  endtask

  task automatic set_req(input sel_t s, input logic v);
    if (s == SEL_ENTRY) entry_req_tb = v;
    else                exit_req_tb  = v;
  endtask

  task automatic check_free();
    @(negedge clk);
    @(negedge clk);
    check("free", {24'd0, o_free}, 32'(m_cap - m_count));
  endtask

  task automatic serve(input sel_t s);
    int w;
    @(negedge clk);
    set_req(s, 1'b1);
    model_push(s);
    wait_pulse(s, w);
    check("latency", 32'(w), 32'd3);
    set_req(s, 1'b0);
    check_free();
  endtask

  task automatic tie();
    int   w;
    sel_t win, lose;
    @(negedge clk);
    entry_req_tb = 1'b1;
    exit_req_tb  = 1'b1;
    win  = model_tie_winner();
    lose = (win == SEL_ENTRY) ? SEL_EXIT : SEL_ENTRY;
    model_push(win);
    model_push(lose);
    wait_pulse(win, w);
    check("tie_win_latency", 32'(w), 32'd3);
    set_req(win, 1'b0);
    wait_pulse(lose, w);
    check("tie_lose_latency", 32'(w), 32'd4);
    set_req(lose, 1'b0);
    check_free();
  endtask

  task automatic do_reset(input logic which, input int cap);
    @(negedge clk);
    rst = 1'b1;
    entry_req_tb = 1'b0;
    exit_req_tb  = 1'b0;
    cur = which;
    @(negedge clk);
    rst = 1'b0;
    m_count = 0;
    m_cap   = cap;
    m_last  = SEL_EXIT;
    sb_q.delete();
    check("rst_count", {24'd0, o_count}, 32'd0);
    check("rst_free",  {24'd0, o_free},  32'(cap));
    check("rst_empty", {31'd0, o_empty}, 32'd1);
    check("rst_full",  {31'd0, o_full},  32'd0);
    check("rst_pulses", {28'd0, o_eg, o_ed, o_xg, o_xd}, 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    cur = 1'b0;
    entry_req_tb = 1'b0;
    exit_req_tb  = 1'b0;
    repeat (2) @(negedge clk);

    // Single entry, exit back to zero, then an exit on an empty lot.
    do_reset(1'b0, CAP_A);
    serve(SEL_ENTRY);
    serve(SEL_EXIT);
    serve(SEL_EXIT);
    check("empty_after_deny", {31'd0, o_empty}, 32'd1);

    // Ties from count=5 with last service = exit, then with last service = entry.
    for (int i = 0; i < 6; i++) serve(SEL_ENTRY);
    serve(SEL_EXIT);
    tie();
    tie();
    serve(SEL_ENTRY);
    tie();

    // Entry held long after its grant while an exit waits behind it.
    @(negedge clk);
    entry_req_tb = 1'b1;
    model_push(SEL_ENTRY);
    wait_pulse(SEL_ENTRY, w);
    check("hold_latency", 32'(w), 32'd3);
    exit_req_tb = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_state", 32'(dut_a.r_state), 32'(ST_WAIT_DROP));
    model_push(SEL_EXIT);
    entry_req_tb = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_exit_count", {24'd0, o_count}, 32'(m_count));
    wait_pulse(SEL_EXIT, w);
    check("pending_exit_latency", 32'(w), 32'd1);
    exit_req_tb = 1'b0;
    check_free();

    // Reset asserted during CALC aborts the entry without any response.
    @(negedge clk);
    entry_req_tb = 1'b1;
    @(negedge clk);
    check("abort_in_calc", 32'(dut_a.r_state), 32'(ST_CALC));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    entry_req_tb = 1'b0;
    m_count = 0;
    m_last  = SEL_EXIT;
    check("abort_count", {24'd0, o_count}, 32'd0);
    check("abort_free",  {24'd0, o_free},  32'(CAP_A));
    check("abort_state", 32'(dut_a.r_state), 32'(ST_IDLE));
    check("abort_pulses", {28'd0, o_eg, o_ed, o_xg, o_xd}, 32'd0);
    repeat (5) @(negedge clk);

    // Small lot: three entries fit, the fourth is refused.
    do_reset(1'b1, CAP_B);
    for (int i = 0; i < 4; i++) serve(SEL_ENTRY);
    check("cap3_count", {24'd0, o_count}, 32'd3);
    check("cap3_full",  {31'd0, o_full},  32'd1);
    check("cap3_free",  {24'd0, o_free},  32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
